// File: rtl/delay_line_pkg.sv
// Shared constants, helper function and stage record for the delay line.
// Imported by dl_stage and param_delay_line.
package delay_line_pkg;

    localparam int DL_WIDTH_DEF = 8;
    localparam int DL_DEPTH_DEF = 4;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [DL_WIDTH_DEF-1:0] data;
    } dl_rec_t;

endpackage

// File: rtl/dl_stage.sv
// One {valid, data} register of the delay line.
// Priority on each edge: rst > flush > en > hold.
module dl_stage
    import delay_line_pkg::*;
#(
    parameter int WIDTH = DL_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             v,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t r;

    // Flush clears only the valid bit; data is left in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (flush) begin
            r.valid <= 1'b0;
        end else if (en) begin
            r <= '{valid: v, data: d};
        end
    end

    assign q       = r.data;
    assign q_valid = r.valid;

endmodule

// File: rtl/param_delay_line.sv
// DEPTH-stage WIDTH-bit delay line with valid, stall, flush, tap and fill count.
// Define DELAY_LINE_ZERO_INVALID_EN to force d_out/tap_out to 0 when invalid.
module param_delay_line
    import delay_line_pkg::*;
#(
    parameter  int WIDTH = DL_WIDTH_DEF,
    parameter  int DEPTH = DL_DEPTH_DEF,
    localparam int TAP_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] d_out,
    output logic             d_out_valid,
    output logic [WIDTH-1:0] tap_out,
    output logic             tap_valid,
    output logic [CNT_W-1:0] fill_cnt
);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] tap_raw;
    logic             tap_raw_v;
    logic [CNT_W-1:0] cnt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            dl_stage #(.WIDTH(WIDTH)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .en      (en),
                .d       (d_in),
                .v       (d_valid),
                .q       (data[i]),
                .q_valid (valid[i])
            );
        end else begin : g_body
            dl_stage #(.WIDTH(WIDTH)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .en      (en),
                .d       (data[i-1]),
                .v       (valid[i-1]),
                .q       (data[i]),
                .q_valid (valid[i])
            );
        end
    end

    // Tracks popcount(valid) incrementally: one in, one out per shift.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(d_valid) - CNT_W'(valid[DEPTH-1]);
        end
    end

    assign fill_cnt = cnt;

    always_comb begin
        tap_raw   = '0;
        tap_raw_v = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAP_W'(i)) begin
                tap_raw   = data[i];
                tap_raw_v = valid[i];
            end
        end
    end

    assign d_out_valid = valid[DEPTH-1];
    assign tap_valid   = tap_raw_v;

`ifdef DELAY_LINE_ZERO_INVALID_EN
    assign d_out   = valid[DEPTH-1] ? data[DEPTH-1] : '0;
    assign tap_out = tap_raw_v ? tap_raw : '0;
`else
    assign d_out   = data[DEPTH-1];
    assign tap_out = tap_raw;
`endif

endmodule

// File: tb/tb_param_delay_line.sv
// Bench for param_delay_line: queue-based reference model, per-cycle compare,
// directed literal checks, then randomized traffic on DEPTH=4 and DEPTH=3 builds.
module tb_param_delay_line;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       d_valid = 1'b0;
    logic [1:0] tap_sel = 2'd0;

    logic [7:0] d_out4, tap_out4, d_out3, tap_out3;
    logic       dov4, tv4, dov3, tv3;
    logic [2:0] fill4;
    logic [1:0] fill3;

    int total = 0;
    int bad = 0;
    bit ok = 0;

    logic [8:0] m4[$];
    logic [8:0] m3[$];

    always #5 clk = ~clk;

    param_delay_line #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .d_in(d_in), .d_valid(d_valid), .tap_sel(tap_sel),
        .d_out(d_out4), .d_out_valid(dov4), .tap_out(tap_out4),
        .tap_valid(tv4), .fill_cnt(fill4)
    );

    param_delay_line #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .d_in(d_in), .d_valid(d_valid), .tap_sel(tap_sel),
        .d_out(d_out3), .d_out_valid(dov3), .tap_out(tap_out3),
        .tap_valid(tv3), .fill_cnt(fill3)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Visible word: optionally zero the data of an invalid entry.
    function automatic logic [8:0] vis(input logic [8:0] e);
`ifdef DELAY_LINE_ZERO_INVALID_EN
        return e[8] ? e : 9'h000;
`else
        return e;
`endif
    endfunction

    function automatic logic [8:0] at(input logic [8:0] q[$], input int i);
        if (i >= q.size()) return 9'h000;
        return vis(q[i]);
    endfunction

    function automatic int pop(input logic [8:0] q[$]);
        int n;
        n = 0;
        foreach (q[i]) if (q[i][8]) n++;
        return n;
    endfunction

    // Model: index 0 is the newest entry, the last index is the output stage.
    always @(posedge clk) begin
        if (rst) begin
            m4 = {};
            m3 = {};
            repeat (4) m4.push_back(9'h000);
            repeat (3) m3.push_back(9'h000);
            ok = 1;
        end else if (flush) begin
            foreach (m4[i]) m4[i] = {1'b0, m4[i][7:0]};
            foreach (m3[i]) m3[i] = {1'b0, m3[i][7:0]};
        end else if (en) begin
            m4.push_front({d_valid, d_in});
            m3.push_front({d_valid, d_in});
            void'(m4.pop_back());
            void'(m3.pop_back());
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (ok) begin
            e = at(m4, 3);
            check("d4_out", {24'h0, d_out4}, {24'h0, e[7:0]});
            check("d4_valid", {31'h0, dov4}, {31'h0, e[8]});
            e = at(m4, int'(tap_sel));
            check("d4_tap", {24'h0, tap_out4}, {24'h0, e[7:0]});
            check("d4_tapv", {31'h0, tv4}, {31'h0, e[8]});
            check("d4_fill", {29'h0, fill4}, pop(m4));
            e = at(m3, 2);
            check("d3_out", {24'h0, d_out3}, {24'h0, e[7:0]});
            check("d3_valid", {31'h0, dov3}, {31'h0, e[8]});
            e = at(m3, int'(tap_sel));
            check("d3_tap", {24'h0, tap_out3}, {24'h0, e[7:0]});
            check("d3_tapv", {31'h0, tv3}, {31'h0, e[8]});
            check("d3_fill", {30'h0, fill3}, pop(m3));
        end
    end

    task automatic step(input logic r, input logic f, input logic e,
                        input logic v, input logic [7:0] d);
        rst = r;
        flush = f;
        en = e;
        d_valid = v;
        d_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [7:0] o, input logic ov,
                       input logic [2:0] f);
        check({nm, "_dout"}, {24'h0, d_out4}, {24'h0, o});
        check({nm, "_dval"}, {31'h0, dov4}, {31'h0, ov});
        check({nm, "_fill"}, {29'h0, fill4}, {29'h0, f});
    endtask

    initial begin
        logic [7:0] pat [4];
        pat[0] = 8'h44; pat[1] = 8'h33; pat[2] = 8'h22; pat[3] = 8'h11;

        // reset held with live-looking inputs
        step(1, 0, 1, 1, 8'hFF); lit("rst0", 8'h00, 0, 3'd0);
        step(1, 0, 1, 1, 8'hFF); lit("rst1", 8'h00, 0, 3'd0);

        // latency and fill growth
        step(0, 0, 1, 1, 8'h11); lit("lat1", 8'h00, 0, 3'd1);
        step(0, 0, 1, 1, 8'h22); lit("lat2", 8'h00, 0, 3'd2);
        step(0, 0, 1, 1, 8'h33); lit("lat3", 8'h00, 0, 3'd3);
        step(0, 0, 1, 1, 8'h44); lit("lat4", 8'h11, 1, 3'd4);

        // tap sweep on the full pipeline
        en = 0;
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i);
            #1;
            check("tap_lit", {24'h0, tap_out4}, {24'h0, pat[i]});
            check("tapv_lit", {31'h0, tv4}, 32'd1);
        end
        check("tap3_oor", {23'h0, tv3, tap_out3}, 32'h0);
        tap_sel = 2'd0;
        step(0, 0, 1, 1, 8'h55); lit("lat5", 8'h22, 1, 3'd4);

        // flush beats enable; data stays, valid goes
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 1, 8'h11);
        step(0, 0, 1, 1, 8'h22);
        step(0, 0, 1, 1, 8'h33);
        step(0, 0, 1, 1, 8'h44);
        step(0, 1, 1, 1, 8'h99);
`ifdef DELAY_LINE_ZERO_INVALID_EN
        lit("flush", 8'h00, 0, 3'd0);
        check("flush_tap", {24'h0, tap_out4}, 32'h00);
`else
        lit("flush", 8'h11, 0, 3'd0);
        check("flush_tap", {24'h0, tap_out4}, 32'h44);
`endif

        // stall
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 1, 8'hA1);
        step(0, 0, 1, 1, 8'hA2); lit("stl0", 8'h00, 0, 3'd2);
        step(0, 0, 0, 1, 8'hEE); lit("stl1", 8'h00, 0, 3'd2);
        step(0, 0, 0, 1, 8'hEE); lit("stl2", 8'h00, 0, 3'd2);
        step(0, 0, 0, 1, 8'hEE); lit("stl3", 8'h00, 0, 3'd2);
        step(0, 0, 1, 1, 8'hA3); lit("stl4", 8'h00, 0, 3'd3);
        step(0, 0, 1, 1, 8'hA4); lit("stl5", 8'hA1, 1, 3'd4);

        // bubbles, then mid-stream reset
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1'(~i[0]), 8'(i + 1));
        check("bub_fill", {29'h0, fill4}, 32'd2);
        step(1, 0, 1, 1, 8'h77);
        check("mrst_all", {15'h0, d_out4, dov4, tap_out4, tv4, fill4}, 32'h0);
        step(0, 0, 1, 1, 8'h5A);
        step(0, 0, 1, 0, 8'h01);
        step(0, 0, 1, 0, 8'h02);
        check("mrst_early", {31'h0, dov4}, 32'd0);
        step(0, 0, 1, 0, 8'h03);
        check("mrst_out", {23'h0, dov4, d_out4}, {23'h0, 1'b1, 8'h5A});

        // randomized traffic checked by the per-cycle compare
        for (int i = 0; i < 600; i++) begin
            tap_sel = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 8'($urandom));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
